io_port_ctrl: RTL and testbench

IO_PORT_CTRL -- requirements
Module: io_port_ctrl

---
 rtl/io_port_ctrl.sv | 119 +++++++++++
 tb/tb_io_port_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/io_port_ctrl.sv
// Memory-mapped GPIO block: output register with set/clear/toggle aliases,
// synchronised inputs and edge-triggered pending bits that drive a level irq.
module io_port_ctrl #(
  parameter int WIDTH       = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  input  logic             bus_we,
  input  logic             bus_re,
  output logic [31:0]      bus_rdata,
  output logic             bus_ready,
  input  logic [WIDTH-1:0] io_input_bus,
  output logic [WIDTH-1:0] io_output_bus,
  output logic             irq
);

  localparam logic [2:0] ADDR_OUT     = 3'd0;
  localparam logic [2:0] ADDR_OUT_SET = 3'd1;
  localparam logic [2:0] ADDR_OUT_CLR = 3'd2;
  localparam logic [2:0] ADDR_OUT_TGL = 3'd3;
  localparam logic [2:0] ADDR_IN      = 3'd4;
  localparam logic [2:0] ADDR_RISE_EN = 3'd5;
  localparam logic [2:0] ADDR_FALL_EN = 3'd6;
  localparam logic [2:0] ADDR_PENDING = 3'd7;

  localparam logic [2:0] WARM_LOAD = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] out_q, rise_en_q, fall_en_q, pend_q, prev_q;
  logic [WIDTH-1:0] out_d, rise_en_d, fall_en_d, pend_d, clr_mask;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_sync, events, rd_val, wd;
  logic [31:0]      rd_word, rdata_q;
  logic             ready_q;
  logic [2:0]       warm_q;
  logic             armed;
  logic             unused_wdata;

  assign wd           = bus_wdata[WIDTH-1:0];
  assign unused_wdata = ^bus_wdata;
  assign in_sync      = sync_q[SYNC_STAGES-1];
  assign armed        = (warm_q == 3'd0);

  // Edge events are masked during warm-up so pins held high through reset
  // do not look like rising edges once the synchroniser fills.
  assign events = armed ? ((in_sync & ~prev_q & rise_en_q) |
                           (~in_sync & prev_q & fall_en_q)) : '0;

  always_comb begin
    rd_val = '0;
    case (bus_addr)
      ADDR_OUT:     rd_val = out_q;
      ADDR_IN:      rd_val = in_sync;
      ADDR_RISE_EN: rd_val = rise_en_q;
      ADDR_FALL_EN: rd_val = fall_en_q;
      ADDR_PENDING: rd_val = pend_q;
      default:      rd_val = '0;
    endcase
    rd_word = '0;
    rd_word[WIDTH-1:0] = rd_val;
  end

  always_comb begin
    out_d     = out_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    clr_mask  = '0;
    if (bus_we) begin
      case (bus_addr)
        ADDR_OUT:     out_d     = wd;
        ADDR_OUT_SET: out_d     = out_q | wd;
        ADDR_OUT_CLR: out_d     = out_q & ~wd;
        ADDR_OUT_TGL: out_d     = out_q ^ wd;
        ADDR_RISE_EN: rise_en_d = wd;
        ADDR_FALL_EN: fall_en_d = wd;
        ADDR_PENDING: clr_mask  = wd;
        default:      ;
      endcase
    end
    // A new event outranks a simultaneous write-1-to-clear.
    pend_d = (pend_q & ~clr_mask) | events;
  end

  // Bus handshake: bus_we/bus_re are single-cycle strobes accepted at the
  // edge they are high (no back-pressure); bus_ready pulses for exactly the
  // following cycle and bus_rdata is valid from then until the next read.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      prev_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      warm_q    <= WARM_LOAD;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      out_q     <= out_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      prev_q    <= in_sync;
      ready_q   <= bus_we | bus_re;
      if (bus_re) rdata_q <= rd_word;
      if (!armed) warm_q <= warm_q - 3'd1;
      sync_q[0] <= io_input_bus;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign bus_rdata     = rdata_q;
  assign bus_ready     = ready_q;
  assign io_output_bus = out_q;
  assign irq           = |pend_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed bench for io_port_ctrl (WIDTH=11, SYNC_STAGES=2) with immediate
// assertions at every check point.
module tb_io_port_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we, bus_re;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [10:0] io_input_bus;
  logic [10:0] io_output_bus;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  io_port_ctrl #(.WIDTH(11), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .io_input_bus(io_input_bus), .io_output_bus(io_output_bus),
    .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs and samples move 1 time unit after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1'b1;
    tick();
    bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus_addr = a; bus_re = 1'b1;
    tick();
    bus_re = 1'b0;
    d = bus_rdata;
  endtask

  logic [31:0] rd;

  initial begin
    reset = 1'b1; bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_re = 1'b0;
    io_input_bus = 11'h7FF;
    tick(3);
    chk("rst_out", io_output_bus, 32'h0);
    chk("rst_irq", irq, 32'h0);
    chk("rst_ready", bus_ready, 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);

    // Pins high through reset must not raise rise events after warm-up.
    reset = 1'b0;
    bus_write(3'd5, 32'h7FF);
    chk("we_ready", bus_ready, 32'h1);
    tick(6);
    chk("ready_idle", bus_ready, 32'h0);
    bus_read(3'd7, rd);
    chk("warm_pending", rd, 32'h0);
    chk("warm_irq", irq, 32'h0);
    bus_read(3'd4, rd);
    chk("in_read", rd, 32'h7FF);
    chk("re_ready", bus_ready, 32'h1);

    // OUT and its set/clear/toggle aliases.
    bus_write(3'd0, 32'h0F0);
    chk("out_wr", io_output_bus, 32'h0F0);
    bus_write(3'd1, 32'h003);
    chk("out_set", io_output_bus, 32'h0F3);
    bus_write(3'd2, 32'h010);
    chk("out_clr", io_output_bus, 32'h0E3);
    bus_write(3'd3, 32'h401);
    chk("out_tgl", io_output_bus, 32'h4E2);
    chk("tgl_ready", bus_ready, 32'h1);
    bus_read(3'd0, rd);
    chk("out_read", rd, 32'h4E2);
    bus_read(3'd1, rd);
    chk("set_read0", rd, 32'h0);
    bus_write(3'd4, 32'h123);
    chk("in_wr_ignored_out", io_output_bus, 32'h4E2);

    // Rising-edge capture on pin0.
    bus_write(3'd5, 32'h001);
    bus_write(3'd6, 32'h000);
    io_input_bus = 11'h000;
    tick(5);
    bus_write(3'd7, 32'h7FF);
    chk("pend_clear", irq, 32'h0);
    io_input_bus = 11'h001;
    tick(2);
    chk("rise_k1_irq", irq, 32'h0);
    tick();
    chk("rise_k2_irq", irq, 32'h1);
    bus_read(3'd7, rd);
    chk("rise_pend", rd, 32'h001);
    bus_write(3'd7, 32'h001);
    chk("w1c_irq", irq, 32'h0);

    // Falling event on pin2 coinciding with a W1C of bit 2: event wins.
    bus_write(3'd6, 32'h004);
    io_input_bus = 11'h005;
    tick(5);
    chk("fall_pre_irq", irq, 32'h0);
    io_input_bus = 11'h001;
    tick(2);
    bus_write(3'd7, 32'h004);
    chk("event_wins_irq", irq, 32'h1);
    bus_read(3'd7, rd);
    chk("event_wins_pend", rd, 32'h004);
    bus_write(3'd6, 32'h000);
    chk("en_clr_keeps", irq, 32'h1);
    bus_write(3'd7, 32'h004);
    chk("fall_cleared", irq, 32'h0);

    // Simultaneous read and write of OUT returns the pre-write value.
    bus_write(3'd0, 32'h123);
    bus_addr = 3'd0; bus_wdata = 32'h456; bus_we = 1'b1; bus_re = 1'b1;
    tick();
    bus_we = 1'b0; bus_re = 1'b0;
    chk("rw_rdata", bus_rdata, 32'h123);
    chk("rw_out", io_output_bus, 32'h456);
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_read(3'd5, rd);
    chk("rise_en_mask", rd, 32'h7FF);

    // Raise a pending bit, then assert reset while a read is in flight.
    io_input_bus = 11'h021;
    tick(4);
    chk("pre_rst_irq", irq, 32'h1);
    bus_addr = 3'd7; bus_re = 1'b1;
    tick();
    bus_re = 1'b0;
    reset = 1'b1;
    tick();
    chk("midrd_ready", bus_ready, 32'h0);
    chk("midrd_rdata", bus_rdata, 32'h0);
    chk("midrd_out", io_output_bus, 32'h0);
    chk("midrd_irq", irq, 32'h0);
    reset = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
